// File: rtl/para_stat.sv
// para_stat: windowed statistics over a stream of signed samples.
// Accumulates N = 2^k accepted samples (k latched from cfg_log2 at window
// start, clamped to LOG2_MAX) and publishes rounded mean, max and min one
// cycle after the closing sample, with a one-cycle sta_vld pulse.
//
// Ports:
//   clk_sys       system clock, rising edge
//   rst           asynchronous active-high reset
//   sm_data       signed sample, DW bits
//   sm_vld        sample qualifier, one sample per high cycle
//   cfg_log2      window length select (N = 2^cfg_log2)
//   clr           synchronous abort of the open window
//   sta_para_ave  rounded signed mean of last completed window
//   sta_para_max  signed maximum of last completed window
//   sta_para_min  signed minimum of last completed window
//   sta_vld       one-cycle pulse when new results are published
//   sta_win_cnt   completed-window count, wraps at 16 bits
module para_stat #(
    parameter int unsigned DW       = 16,
    parameter int unsigned LOG2_MAX = 16
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic [DW-1:0] sm_data,
    input  logic          sm_vld,
    input  logic [4:0]    cfg_log2,
    input  logic          clr,
    output logic [DW-1:0] sta_para_ave,
    output logic [DW-1:0] sta_para_max,
    output logic [DW-1:0] sta_para_min,
    output logic          sta_vld,
    output logic [15:0]   sta_win_cnt
);

    localparam int unsigned AW = DW + LOG2_MAX;
    // one spare bit so 2^LOG2_MAX is representable when forming N-1
    localparam int unsigned CW = LOG2_MAX + 1;

    logic [CW-1:0]        cnt;
    logic [4:0]           k_q;
    logic signed [AW-1:0] acc;
    logic signed [DW-1:0] run_max;
    logic signed [DW-1:0] run_min;

    logic                 accept_c;
    logic                 first_c;
    logic                 last_c;
    logic [4:0]           cfg_clamp_c;
    logic [4:0]           k_c;
    logic signed [AW-1:0] sum_c;
    logic signed [AW-1:0] rnd_c;
    logic signed [DW-1:0] max_c;
    logic signed [DW-1:0] min_c;

    // Per-sample datapath: window length, running sum and extrema including
    // the current sample.
    always_comb begin
        accept_c    = sm_vld & ~clr;
        first_c     = (cnt == '0);
        cfg_clamp_c = (32'(cfg_log2) > LOG2_MAX) ? 5'(LOG2_MAX) : cfg_log2;
        k_c         = first_c ? cfg_clamp_c : k_q;
        last_c      = (cnt == ((CW'(1) << k_c) - CW'(1)));
        sum_c       = (first_c ? '0 : acc) + AW'($signed(sm_data));
        rnd_c       = (k_c == 5'd0) ? '0 : AW'(AW'(1) << (k_c - 5'd1));
        max_c       = (first_c || ($signed(sm_data) > run_max)) ? sm_data : run_max;
        min_c       = (first_c || ($signed(sm_data) < run_min)) ? sm_data : run_min;
    end

    // Window state and published results.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            k_q          <= '0;
            acc          <= '0;
            run_max      <= '0;
            run_min      <= '0;
            sta_para_ave <= '0;
            sta_para_max <= '0;
            sta_para_min <= '0;
            sta_vld      <= 1'b0;
            sta_win_cnt  <= '0;
        end else begin
            sta_vld <= 1'b0;
            if (clr) begin
                cnt     <= '0;
                acc     <= '0;
                run_max <= '0;
                run_min <= '0;
            end else if (accept_c) begin
                k_q <= k_c;
                if (last_c) begin
                    cnt          <= '0;
                    acc          <= '0;
                    run_max      <= '0;
                    run_min      <= '0;
                    // arithmetic shift of the rounded sum; result fits DW
                    sta_para_ave <= DW'((sum_c + rnd_c) >>> k_c);
                    sta_para_max <= max_c;
                    sta_para_min <= min_c;
                    sta_vld      <= 1'b1;
                    sta_win_cnt  <= sta_win_cnt + 16'd1;
                end else begin
                    cnt     <= cnt + CW'(1);
                    acc     <= sum_c;
                    run_max <= max_c;
                    run_min <= min_c;
                end
            end
        end
    end

endmodule

// File: doc/para_stat.md
PARA_STAT -- requirements
Module: para_stat

Interface
REQ-001 Parameter DW, default 16, signed sample width in bits.
REQ-002 Parameter LOG2_MAX, default 16, largest supported log2 window length.
REQ-003 clk_sys  input  1  system clock; all logic rising-edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-high.
REQ-005 sm_data  input  DW  signed two's-complement sample.
REQ-006 sm_vld  input  1  sample-valid qualifier; one sample per high cycle.
REQ-007 cfg_log2  input  5  window length select, N = 2^cfg_log2.
REQ-008 clr  input  1  synchronous window abort / restart.
REQ-009 sta_para_ave  output  DW  rounded signed mean of last completed window.
REQ-010 sta_para_max  output  DW  signed maximum of last completed window.
REQ-011 sta_para_min  output  DW  signed minimum of last completed window.
REQ-012 sta_vld  output  1  one-cycle pulse, new window results present.
REQ-013 sta_win_cnt  output  16  count of completed windows, wraps 0xFFFF->0x0000.

Function
REQ-014 Sample accepted only when sm_vld=1 and clr=0; sm_data ignored otherwise.
REQ-015 Window length k latched from cfg_log2 when first sample of a window is accepted; cfg_log2 changes mid-window have no effect on the open window.
REQ-016 cfg_log2 > LOG2_MAX clamped to LOG2_MAX at latch time.
REQ-017 Sample counter 0..N-1; accepting sample at count N-1 closes window and returns count to 0.
REQ-018 Accumulator width DW+LOG2_MAX, sm_data sign-extended before adding; no overflow possible.
REQ-019 Running max/min updated on every accepted sample; first sample of a window loads both directly.
REQ-020 On window close, final sum includes closing sample: ave = (sum + 2^(k-1)) >>> k (arithmetic); k=0: ave = sum.
REQ-021 Rounded result always fits DW signed range; low DW bits taken, no saturation logic.
REQ-022 Max/min published include closing sample.
REQ-023 Latency: sta_para_ave/max/min registered and sta_vld=1 in cycle after closing sample accepted.
REQ-024 sta_vld high exactly one cycle per closed window; published outputs hold until next close.
REQ-025 Back-to-back: sample accepted in cycle after close starts new window; no dead cycles, no sample lost.
REQ-026 sta_win_cnt increments in same cycle sta_vld asserts.
REQ-027 clr=1: counter, accumulator, running max/min cleared; published outputs, sta_win_cnt held; no sta_vld; simultaneous sm_vld sample dropped.
REQ-028 clr in closing cycle: window discarded, no sta_vld.
REQ-029 Gaps in sm_vld of any length pause accumulation without altering state.

Reset
REQ-030 rst=1: sta_para_ave/max/min=0, sta_vld=0, sta_win_cnt=0, counter/accumulator/running max/min cleared, immediately without clock.
REQ-031 First accepted sample after rst release opens new window, k latched then; rst mid-window discards partial window.

Verification
REQ-032 cfg_log2=3, samples 1..8 contiguous -> one cycle after 8th: ave=5, max=8, min=1, sta_vld one cycle, sta_win_cnt=1.
REQ-033 cfg_log2=2, samples -1,-2,-3,-4 -> ave=0xFFFE (-2), max=0xFFFF, min=0xFFFC.
REQ-034 cfg_log2=16, 65536 samples of 0x7FFF then 65536 of 0x8000 back-to-back -> ave 0x7FFF then 0x8000, two sta_vld pulses 65536 cycles apart.
REQ-035 cfg_log2=3, switch to 1 after 3rd sample, random sm_vld gaps -> first close after 8th sample, next after 2 more; cfg_log2=0 -> every sample echoed with sta_vld.
REQ-036 cfg_log2=3, 5 samples, clr pulse, samples 10..17 -> no sta_vld on clr; ave=14 (mean 13.5 rounded up), max=17, min=10.
REQ-037 rst asserted after 4 of 8 samples, between clock edges -> outputs 0 before next edge; next 8 samples produce correct independent result.
